// File: rtl/r2r_pwm_feeder.sv
// Sample source for the R2R+PWM DAC: FIFO-buffered producer samples, a prefetch
// staging register that keeps dac_val stable ahead of val_req, and underrun tracking.
module r2r_pwm_feeder #(
  parameter int   R2R_BITS  = 4,
  parameter int   PWM_BITS  = 12,
  parameter int   DEPTH     = 16,
  parameter logic [R2R_BITS+PWM_BITS-1:0] IDLE_VAL =
    {1'b1, {(R2R_BITS+PWM_BITS-1){1'b0}}},
  parameter logic HOLD_LAST = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                flush,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [R2R_BITS+PWM_BITS-1:0]        s_data,
  input  logic                                val_req,
  output logic [R2R_BITS+PWM_BITS-1:0]        dac_val,
  output logic [$clog2(DEPTH):0]              level,
  output logic                                underrun,
  output logic [15:0]                         underrun_cnt,
  input  logic                                underrun_clr
);

  localparam int W  = R2R_BITS + PWM_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("r2r_pwm_feeder: DEPTH must be a power of two and >= 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          stg_vld;
  logic          wr_en;
  logic          pop;
  logic          consume;
  logic          und_evt;

  always_comb begin
    s_ready = (level != FULL_LVL) && !flush;
    wr_en   = s_valid && s_ready;
    // Refill is held off on a request cycle so the DAC never sees a mid-edge change.
    pop     = en && !stg_vld && (level != '0) && !val_req && !flush;
    consume = val_req && en && stg_vld && !flush;
    und_evt = val_req && en && !stg_vld;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      stg_vld <= 1'b0;
      dac_val <= IDLE_VAL;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (!en) begin
        stg_vld <= 1'b0;
        dac_val <= IDLE_VAL;
      end else if (pop) begin
        stg_vld <= 1'b1;
        dac_val <= mem[rd_ptr];
      end else if (consume) begin
        stg_vld <= 1'b0;
        if (!HOLD_LAST) dac_val <= IDLE_VAL;
      end
    end
  end

  // Clear beats a coincident underrun; flush leaves the counters alone.
  always_ff @(posedge clk) begin
    if (rst || underrun_clr) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (und_evt) begin
      underrun <= 1'b1;
      if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
